// File: rtl/ibuffer_multiport_if.sv
// Fetch/decode handshake bundle for the multi-port instruction buffer.
interface ibuffer_multiport_if #(
    parameter int FETCH_WIDTH  = 4,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = 16,
    parameter int PC_WIDTH     = 48
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                             redirect_valid;
    logic                             mem_stall;
    logic [FETCH_WIDTH-1:0]           admin2ib_instr_valid;
    logic [32*FETCH_WIDTH-1:0]        admin2ib_instr;
    logic [63:0]                      admin2ib_pc;
    logic [FETCH_WIDTH-1:0]           admin2ib_predicttaken;
    logic [32*FETCH_WIDTH-1:0]        admin2ib_predicttarget;
    logic                             ib2admin_ready;
    logic [DECODE_WIDTH-1:0]          ib2dec_valid;
    logic [32*DECODE_WIDTH-1:0]       ib2dec_instr;
    logic [PC_WIDTH*DECODE_WIDTH-1:0] ib2dec_pc;
    logic [DECODE_WIDTH-1:0]          ib2dec_predicttaken;
    logic [32*DECODE_WIDTH-1:0]       ib2dec_predicttarget;
    logic [DECODE_WIDTH-1:0]          dec2ib_accept;
    logic [CNT_W-1:0]                 ib_count;
    logic                             ib_empty;

    modport master (
        output redirect_valid, mem_stall, admin2ib_instr_valid, admin2ib_instr,
               admin2ib_pc, admin2ib_predicttaken, admin2ib_predicttarget, dec2ib_accept,
        input  ib2admin_ready, ib2dec_valid, ib2dec_instr, ib2dec_pc,
               ib2dec_predicttaken, ib2dec_predicttarget, ib_count, ib_empty
    );

    modport slave (
        input  redirect_valid, mem_stall, admin2ib_instr_valid, admin2ib_instr,
               admin2ib_pc, admin2ib_predicttaken, admin2ib_predicttarget, dec2ib_accept,
        output ib2admin_ready, ib2dec_valid, ib2dec_instr, ib2dec_pc,
               ib2dec_predicttaken, ib2dec_predicttarget, ib_count, ib_empty
    );
endinterface

// File: rtl/ibuffer_multiport.sv
// Multi-port instruction buffer: compacts up to FETCH_WIDTH fetched lanes
// into a circular queue and presents up to DECODE_WIDTH entries to decode.
module ibuffer_multiport #(
    parameter int FETCH_WIDTH  = 4,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = 16,
    parameter int PC_WIDTH     = 48
) (
    input logic               clock,
    input logic               reset,
    ibuffer_multiport_if.slave ib
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic                taken;
        logic [31:0]         target;
        logic [31:0]         instr;
        logic [PC_WIDTH-1:0] pc;
    } entry_t;

    entry_t                             mem [DEPTH];
    logic [PTR_W-1:0]                   head, tail;
    logic [CNT_W-1:0]                   count;
    logic [CNT_W-1:0]                   n_enq, n_deq, enq_amt;
    logic                               do_enq;
    logic [FETCH_WIDTH-1:0][PTR_W-1:0]  wr_idx;
    entry_t [FETCH_WIDTH-1:0]           wr_ent;

    // Ready looks only at the registered count, so fetch sees no input-to-output path.
    assign ib.ib2admin_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_WIDTH);
    assign ib.ib_count       = count;
    assign ib.ib_empty       = (count == '0);

    assign do_enq  = ib.ib2admin_ready && (|ib.admin2ib_instr_valid) && !ib.redirect_valid;
    assign enq_amt = do_enq ? n_enq : '0;

    // Compact valid lanes: each lane's slot is tail plus the number of valid lanes below it.
    always_comb begin
        n_enq = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            wr_idx[i]        = tail + n_enq[PTR_W-1:0];
            wr_ent[i].taken  = ib.admin2ib_predicttaken[i];
            wr_ent[i].target = ib.admin2ib_predicttarget[32*i +: 32];
            wr_ent[i].instr  = ib.admin2ib_instr[32*i +: 32];
            wr_ent[i].pc     = PC_WIDTH'(ib.admin2ib_pc + 64'(4*i));
            if (ib.admin2ib_instr_valid[i]) n_enq = n_enq + 1'b1;
        end
    end

    // Read ports: slot j shows the entry j places past head.
    for (genvar j = 0; j < DECODE_WIDTH; j++) begin : g_rd
        logic [PTR_W-1:0] rd_idx;
        entry_t           rd_ent;
        assign rd_idx = head + PTR_W'(j);
        assign rd_ent = mem[rd_idx];
        assign ib.ib2dec_valid[j]                 = (count > CNT_W'(j)) && !ib.redirect_valid;
        assign ib.ib2dec_instr[32*j +: 32]        = rd_ent.instr;
        assign ib.ib2dec_pc[PC_WIDTH*j +: PC_WIDTH] = rd_ent.pc;
        assign ib.ib2dec_predicttaken[j]          = rd_ent.taken;
        assign ib.ib2dec_predicttarget[32*j +: 32] = rd_ent.target;
    end

    // Count consumed slots; a backend stall blocks every dequeue.
    always_comb begin
        n_deq = '0;
        if (!ib.mem_stall) begin
            for (int j = 0; j < DECODE_WIDTH; j++)
                if (ib.dec2ib_accept[j] && ib.ib2dec_valid[j]) n_deq = n_deq + 1'b1;
        end
    end

    // Pointer/count update; reset beats redirect, redirect discards this cycle's traffic.
    always_ff @(posedge clock) begin
        if (reset || ib.redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + enq_amt[PTR_W-1:0];
            head  <= head + n_deq[PTR_W-1:0];
            count <= count + enq_amt - n_deq;
        end
    end

    // Storage write for the compacted lanes; no reset needed, pointers gate visibility.
    always_ff @(posedge clock) begin
        for (int i = 0; i < FETCH_WIDTH; i++)
            if (!reset && do_enq && ib.admin2ib_instr_valid[i]) mem[wr_idx[i]] <= wr_ent[i];
    end

    // Simulation checks on decode handshake legality and queue sizing.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (!ib.redirect_valid)
                assert (((ib.dec2ib_accept & ~ib.ib2dec_valid) == '0) &&
                        ((ib.dec2ib_accept & (ib.dec2ib_accept + 1'b1)) == '0));
            assert (count <= CNT_W'(DEPTH));
            assert ((DEPTH & (DEPTH - 1)) == 0);
        end
    end
endmodule

// File: tb/tb_ibuffer_multiport.sv
// Self-checking bench for ibuffer_multiport against a queue-based model.
module tb_ibuffer_multiport;
    localparam int FW = 4;
    localparam int DW = 2;
    localparam int DEPTH = 16;
    localparam int PW = 48;

    typedef struct {
        bit          taken;
        bit [31:0]   tgt;
        bit [31:0]   instr;
        bit [PW-1:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    ent_t m_q[$];

    ibuffer_multiport_if #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .PC_WIDTH(PW)) ibf ();

    ibuffer_multiport #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .PC_WIDTH(PW)) dut (
        .clock (clk),
        .reset (rst),
        .ib    (ibf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int mmin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit r, input bit rd, input bit st, input logic [FW-1:0] m,
                        input logic [63:0] pc, input int k);
        int  sz, nd;
        bit  rdy;
        ent_t e;
        rst = r;
        ibf.redirect_valid = rd;
        ibf.mem_stall = st;
        ibf.admin2ib_instr_valid = m;
        ibf.admin2ib_pc = pc;
        for (int i = 0; i < FW; i++) begin
            ibf.admin2ib_instr[32*i +: 32] = $urandom;
            ibf.admin2ib_predicttarget[32*i +: 32] = $urandom;
            ibf.admin2ib_predicttaken[i] = 1'($urandom_range(0, 1));
        end
        ibf.dec2ib_accept = DW'((1 << k) - 1);
        #1;
        sz  = m_q.size();
        rdy = (DEPTH - sz) >= FW;
        if (chk_en) begin
            chk("count", 64'(ibf.ib_count), 64'(sz));
            chk("empty", 64'(ibf.ib_empty), 64'(sz == 0));
            chk("ready", 64'(ibf.ib2admin_ready), 64'(rdy));
            for (int j = 0; j < DW; j++) begin
                chk($sformatf("valid%0d", j), 64'(ibf.ib2dec_valid[j]), 64'((sz > j) && !rd));
                if ((sz > j) && !rd) begin
                    chk($sformatf("pc%0d", j), 64'(ibf.ib2dec_pc[PW*j +: PW]), 64'(m_q[j].pc));
                    chk($sformatf("instr%0d", j), 64'(ibf.ib2dec_instr[32*j +: 32]), 64'(m_q[j].instr));
                    chk($sformatf("tgt%0d", j), 64'(ibf.ib2dec_predicttarget[32*j +: 32]), 64'(m_q[j].tgt));
                    chk($sformatf("taken%0d", j), 64'(ibf.ib2dec_predicttaken[j]), 64'(m_q[j].taken));
                end
            end
        end
        if (r || rd) begin
            m_q.delete();
        end else begin
            nd = st ? 0 : mmin(k, mmin(sz, DW));
            for (int j = 0; j < nd; j++) void'(m_q.pop_front());
            if (rdy) begin
                for (int i = 0; i < FW; i++) begin
                    if (m[i]) begin
                        e.taken = ibf.admin2ib_predicttaken[i];
                        e.tgt   = ibf.admin2ib_predicttarget[32*i +: 32];
                        e.instr = ibf.admin2ib_instr[32*i +: 32];
                        e.pc    = PW'(pc + 64'(4 * i));
                        m_q.push_back(e);
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int k, v;
        bit rd;
        rst = 1'b1;
        ibf.redirect_valid = 1'b0;
        ibf.mem_stall = 1'b0;
        ibf.admin2ib_instr_valid = '0;
        ibf.admin2ib_instr = '0;
        ibf.admin2ib_pc = '0;
        ibf.admin2ib_predicttaken = '0;
        ibf.admin2ib_predicttarget = '0;
        ibf.dec2ib_accept = '0;
        @(negedge clk);
        step(1, 0, 0, 4'b0000, 64'h0, 0);
        chk_en = 1'b1;

        // Full group then sparse group, decode idle.
        step(0, 0, 0, 4'b1111, 64'h1000, 0);
        step(0, 0, 0, 4'b1010, 64'h2000, 0);
        step(0, 0, 0, 4'b0000, 64'h0, 0);

        // Fill to 16, fifth group ignored, then drain two pairs.
        step(1, 0, 0, 4'b0000, 64'h0, 0);
        for (int g = 0; g < 5; g++) step(0, 0, 0, 4'b1111, 64'h3000 + 64'(16 * g), 0);
        step(0, 0, 0, 4'b0000, 64'h0, 2);
        step(0, 0, 0, 4'b0000, 64'h0, 2);
        step(0, 0, 0, 4'b0000, 64'h0, 0);

        // Walk head to 14 with 2 left, then enqueue 4 while dequeuing 2 across the wrap.
        step(1, 0, 0, 4'b0000, 64'h0, 0);
        for (int g = 0; g < 4; g++) step(0, 0, 0, 4'b1111, 64'h4000 + 64'(16 * g), 0);
        for (int d = 0; d < 7; d++) step(0, 0, 0, 4'b0000, 64'h0, 2);
        step(0, 0, 0, 4'b1111, 64'h5000, 2);
        step(0, 0, 0, 4'b0000, 64'h0, 2);
        step(0, 0, 0, 4'b0000, 64'h0, 0);

        // Stall holds everything for three cycles.
        step(0, 0, 0, 4'b1111, 64'h6000, 0);
        for (int s = 0; s < 3; s++) step(0, 0, 1, 4'b0000, 64'h0, 2);
        step(0, 0, 0, 4'b0000, 64'h0, 0);

        // Redirect with enqueue and accept in the same cycle.
        step(0, 1, 0, 4'b1111, 64'h7000, 2);
        step(0, 0, 0, 4'b0000, 64'h0, 0);

        // Reset while half full.
        step(0, 0, 0, 4'b1111, 64'h8000, 0);
        step(0, 0, 0, 4'b1111, 64'h8010, 0);
        step(1, 0, 0, 4'b1111, 64'h8020, 0);
        step(0, 0, 0, 4'b0000, 64'h0, 0);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            rd = ($urandom_range(0, 29) == 0);
            v  = rd ? DW : mmin(m_q.size(), DW);
            k  = $urandom_range(0, v);
            step(0, rd, ($urandom_range(0, 7) == 0), FW'($urandom),
                 {$urandom, $urandom}, k);
        end
        step(0, 0, 0, 4'b0000, 64'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
